// File: rtl/addsub_mc_pkg.sv
// Shared ALU definitions: aluc op encoding, add/sub unit state codes and a
// helper for sizing the chunk index register.
package addsub_mc_pkg;

  typedef enum logic [1:0] {
    ALUC_ADDU = 2'b00,
    ALUC_SUBU = 2'b01,
    ALUC_ADD  = 2'b10,
    ALUC_SUB  = 2'b11
  } aluc_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_DONE = 2'b10
  } state_t;

  // Index register width; a single-chunk unit still needs one bit.
  function automatic int idx_width(input int nchunk);
    return (nchunk > 1) ? $clog2(nchunk) : 1;
  endfunction

endpackage

// File: rtl/addsub_mc_if.sv
// Operand/result bus of the multi-cycle add/sub unit. The master side is the
// producer of operands and the consumer of results; the unit is the slave.
interface addsub_mc_if #(
  parameter int WIDTH = 32
);
  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; valid never waits on ready, and payload is stable while valid.
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       aluc;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] r;
  logic             zero;
  logic             carry;
  logic             negative;
  logic             overflow;

  modport master (
    output in_valid, a, b, aluc, out_ready,
    input  in_ready, out_valid, r, zero, carry, negative, overflow
  );

  modport slave (
    input  in_valid, a, b, aluc, out_ready,
    output in_ready, out_valid, r, zero, carry, negative, overflow
  );

endinterface

// File: rtl/addsub_mc_chunk.sv
// CHUNK-bit combinational adder slice with carry in/out, reused every CALC
// cycle by the multi-cycle unit.
module addsub_chunk #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
);

  logic [W:0] sum;

  assign sum  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
  assign s    = sum[W-1:0];
  assign cout = sum[W];

endmodule

// File: rtl/addsub_mc.sv
// Multi-cycle add/subtract unit: CHUNK bits per cycle through a registered
// carry, result and flags registered at the end of the last chunk.
module addsub_mc
  import addsub_mc_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic          clk,
  input  logic          reset,
  addsub_mc_if.slave    bus,
  output logic          busy,
  output state_t        state_dbg
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = idx_width(NCHUNK);
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NCHUNK - 1);

  generate
    if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
      $error("addsub_mc: WIDTH must be an integer multiple of CHUNK");
    end
  endgenerate

  state_t           state_q, state_nxt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             b_msb_q;
  logic             cin_q;
  aluc_t            op_q;
  logic [IDXW-1:0]  idx_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] r_q;
  logic             zero_q, carry_q, negative_q, overflow_q;

  logic [CHUNK-1:0] a_chunk, b_chunk, s_chunk;
  logic             cout;
  logic [WIDTH-1:0] sum_full;
  logic             last;
  logic             f_zero, f_carry, f_negative, f_overflow;

  assign a_chunk = a_q[idx_q*CHUNK +: CHUNK];
  assign b_chunk = b_q[idx_q*CHUNK +: CHUNK];
  assign last    = (idx_q == IDX_LAST);

  addsub_chunk #(.W(CHUNK)) u_chunk (
    .a    (a_chunk),
    .b    (b_chunk),
    .cin  (cin_q),
    .s    (s_chunk),
    .cout (cout)
  );

  // Accumulator with the slice of the current cycle merged in, so the last
  // CALC cycle can register the complete sum directly.
  always_comb begin
    sum_full = acc_q;
    sum_full[idx_q*CHUNK +: CHUNK] = s_chunk;
  end

  // b_q holds ~b for subtraction, so signed overflow uses the original b msb.
  always_comb begin
    f_zero     = ~|sum_full;
    f_carry    = 1'b0;
    f_negative = 1'b0;
    f_overflow = 1'b0;
    case (op_q)
      ALUC_ADDU: f_carry = cout;
      ALUC_SUBU: f_carry = ~cout;
      ALUC_ADD: begin
        f_negative = sum_full[WIDTH-1];
        f_overflow = (a_q[WIDTH-1] == b_msb_q) && (sum_full[WIDTH-1] != a_q[WIDTH-1]);
      end
      ALUC_SUB: begin
        f_negative = sum_full[WIDTH-1];
        f_overflow = (a_q[WIDTH-1] != b_msb_q) && (sum_full[WIDTH-1] != a_q[WIDTH-1]);
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      S_IDLE:  if (bus.in_valid) state_nxt = S_CALC;
      S_CALC:  if (last) state_nxt = S_DONE;
      S_DONE:  if (bus.out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      b_msb_q    <= 1'b0;
      cin_q      <= 1'b0;
      op_q       <= ALUC_ADDU;
      idx_q      <= '0;
      acc_q      <= '0;
      r_q        <= '0;
      zero_q     <= 1'b0;
      carry_q    <= 1'b0;
      negative_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_nxt;
      case (state_q)
        S_IDLE: begin
          if (bus.in_valid) begin
            a_q     <= bus.a;
            b_q     <= bus.aluc[0] ? ~bus.b : bus.b;
            b_msb_q <= bus.b[WIDTH-1];
            cin_q   <= bus.aluc[0];
            op_q    <= aluc_t'(bus.aluc);
            idx_q   <= '0;
          end
        end
        S_CALC: begin
          acc_q <= sum_full;
          cin_q <= cout;
          if (last) begin
            r_q        <= sum_full;
            zero_q     <= f_zero;
            carry_q    <= f_carry;
            negative_q <= f_negative;
            overflow_q <= f_overflow;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.r         = r_q;
  assign bus.zero      = zero_q;
  assign bus.carry     = carry_q;
  assign bus.negative  = negative_q;
  assign bus.overflow  = overflow_q;
  assign busy          = (state_q != S_IDLE);
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_addsub_mc.sv
// Directed bench for addsub_mc: a 32/8 instance for the main function and a
// 32/32 instance for the single-chunk case.
module tb_addsub_mc;
  import addsub_mc_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  addsub_mc_if #(.WIDTH(32)) bus ();
  addsub_mc_if #(.WIDTH(32)) bus2 ();
  logic   busy, busy2;
  state_t st, st2;

  addsub_mc #(.WIDTH(32), .CHUNK(8)) dut (
    .clk(clk), .reset(reset), .bus(bus), .busy(busy), .state_dbg(st)
  );

  addsub_mc #(.WIDTH(32), .CHUNK(32)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2), .busy(busy2), .state_dbg(st2)
  );

  // Flags packed as {zero, carry, negative, overflow}.
  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] av,
                        input logic [31:0] bv, input logic [31:0] er, input logic [3:0] ef);
    int cnt;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.a = av; bus.b = bv; bus.aluc = op;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.a = $urandom; bus.b = $urandom; bus.aluc = 2'($urandom_range(0, 3));
    cnt = 0;
    while (!bus.out_valid && cnt < 20) begin
      @(posedge clk); #1; cnt++;
    end
    n_vec++;
    if (cnt !== 4) begin
      n_err++; $display("FAIL %s latency: got %0d edges, expected 4", name, cnt);
    end
    n_vec++;
    if (bus.r !== er) begin
      n_err++; $display("FAIL %s r: got %h, expected %h", name, bus.r, er);
    end
    n_vec++;
    if ({bus.zero, bus.carry, bus.negative, bus.overflow} !== ef) begin
      n_err++; $display("FAIL %s flags zcnv: got %b, expected %b", name,
                        {bus.zero, bus.carry, bus.negative, bus.overflow}, ef);
    end
    @(posedge clk); #1;
    n_vec++;
    if ({bus.in_ready, bus.out_valid, busy} !== 3'b100) begin
      n_err++; $display("FAIL %s return to idle: got rdy/vld/busy %b, expected 100", name,
                        {bus.in_ready, bus.out_valid, busy});
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if ({bus.in_ready, bus.out_valid, busy} !== 3'b100 || st !== S_IDLE) begin
      n_err++; $display("FAIL reset ctrl: got rdy/vld/busy %b state %0d, expected 100 state 0",
                        {bus.in_ready, bus.out_valid, busy}, st);
    end
    n_vec++;
    if ({bus.r, bus.zero, bus.carry, bus.negative, bus.overflow} !== 36'h0) begin
      n_err++; $display("FAIL reset outputs: got r=%h zcnv=%b, expected all 0", bus.r,
                        {bus.zero, bus.carry, bus.negative, bus.overflow});
    end
    n_vec++;
    if ({bus2.in_ready, bus2.out_valid, busy2, bus2.r} !== {3'b100, 32'h0}) begin
      n_err++; $display("FAIL reset single-chunk: got rdy/vld/busy %b r=%h, expected 100 r=0",
                        {bus2.in_ready, bus2.out_valid, busy2}, bus2.r);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_addu();
    run_op("addu_wrap", ALUC_ADDU, 32'hFFFF_FFFF, 32'h1, 32'h0, 4'b1100);
    run_op("addu_chunk_carry", ALUC_ADDU, 32'h0000_00FF, 32'h1, 32'h0000_0100, 4'b0000);
    run_op("addu_plain", ALUC_ADDU, 32'h1234_5678, 32'h0F0F_0F0F, 32'h2143_6587, 4'b0000);
  endtask

  task automatic test_add();
    run_op("add_ovf", ALUC_ADD, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 4'b0011);
    run_op("add_neg", ALUC_ADD, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 4'b0010);
  endtask

  task automatic test_subu();
    run_op("subu_borrow", ALUC_SUBU, 32'h3, 32'h5, 32'hFFFF_FFFE, 4'b0100);
    run_op("subu_noborrow", ALUC_SUBU, 32'h5, 32'h3, 32'h2, 4'b0000);
  endtask

  task automatic test_sub();
    run_op("sub_ovf", ALUC_SUB, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 4'b0001);
    run_op("sub_zero", ALUC_SUB, 32'h5, 32'h5, 32'h0, 4'b1000);
  endtask

  task automatic test_backpressure();
    int cnt;
    int bad;
    bus.out_ready = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.a = 32'h100; bus.b = 32'h23; bus.aluc = ALUC_ADDU;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    cnt = 0;
    while (!bus.out_valid && cnt < 20) begin
      @(posedge clk); #1; cnt++;
    end
    n_vec++;
    if (bus.r !== 32'h123 || cnt !== 4) begin
      n_err++; $display("FAIL bp first result: got r=%h after %0d edges, expected 123 after 4",
                        bus.r, cnt);
    end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1; bus.a = 32'hFFFF_FFFF; bus.b = 32'h8000_0001; bus.aluc = ALUC_SUB;
      @(posedge clk); #1;
      if (bus.r !== 32'h123 || {bus.zero, bus.carry, bus.negative, bus.overflow} !== 4'b0000 ||
          bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || st !== S_DONE)
        bad++;
    end
    n_vec++;
    if (bad !== 0) begin
      n_err++; $display("FAIL bp hold: got %0d disturbed cycles, expected 0", bad);
    end
    @(negedge clk);
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if ({bus.in_ready, bus.out_valid, busy} !== 3'b100 || bus.r !== 32'h123) begin
      n_err++; $display("FAIL bp release: got rdy/vld/busy %b r=%h, expected 100 r=123",
                        {bus.in_ready, bus.out_valid, busy}, bus.r);
    end
  endtask

  task automatic test_reset_mid_calc();
    int seen;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.a = 32'h5; bus.b = 32'h7; bus.aluc = ALUC_SUB;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if ({bus.in_ready, bus.out_valid, busy} !== 3'b100 || bus.r !== 32'h0 ||
        {bus.zero, bus.carry, bus.negative, bus.overflow} !== 4'b0000) begin
      n_err++; $display("FAIL reset mid-calc: got rdy/vld/busy %b r=%h zcnv=%b, expected 100 0 0000",
                        {bus.in_ready, bus.out_valid, busy}, bus.r,
                        {bus.zero, bus.carry, bus.negative, bus.overflow});
    end
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid !== 1'b0 || busy !== 1'b0) seen++;
    end
    n_vec++;
    if (seen !== 0) begin
      n_err++; $display("FAIL reset discard: got %0d active cycles, expected 0", seen);
    end
    run_op("after_reset", ALUC_ADDU, 32'h2, 32'h3, 32'h5, 4'b0000);
  endtask

  task automatic test_back_to_back();
    int accepts;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.a = 32'h1; bus.b = 32'h1; bus.aluc = ALUC_ADDU;
    accepts = 0;
    for (int i = 0; i < 18; i++) begin
      if (bus.in_ready) accepts++;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    n_vec++;
    if (accepts !== 3) begin
      n_err++; $display("FAIL back_to_back accepts: got %0d in 18 cycles, expected 3", accepts);
    end
    n_vec++;
    if (bus.r !== 32'h2) begin
      n_err++; $display("FAIL back_to_back r: got %h, expected 2", bus.r);
    end
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic test_single_chunk();
    @(negedge clk);
    bus2.in_valid = 1'b1; bus2.a = 32'h1; bus2.b = 32'h2; bus2.aluc = ALUC_ADD;
    @(posedge clk); #1;
    bus2.in_valid = 1'b0;
    n_vec++;
    if (bus2.out_valid !== 1'b0 || busy2 !== 1'b1) begin
      n_err++; $display("FAIL chunk32 calc: got vld/busy %b, expected 01", {bus2.out_valid, busy2});
    end
    @(posedge clk); #1;
    n_vec++;
    if (bus2.out_valid !== 1'b1 || bus2.r !== 32'h3 ||
        {bus2.zero, bus2.carry, bus2.negative, bus2.overflow} !== 4'b0000) begin
      n_err++; $display("FAIL chunk32 result: got vld=%b r=%h zcnv=%b, expected 1 3 0000",
                        bus2.out_valid, bus2.r,
                        {bus2.zero, bus2.carry, bus2.negative, bus2.overflow});
    end
    @(posedge clk); #1;
    n_vec++;
    if (bus2.in_ready !== 1'b1) begin
      n_err++; $display("FAIL chunk32 idle: got in_ready %b, expected 1", bus2.in_ready);
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.aluc = '0; bus.out_ready = 1'b1;
    bus2.in_valid = 1'b0; bus2.a = '0; bus2.b = '0; bus2.aluc = '0; bus2.out_ready = 1'b1;
    test_reset();
    test_addu();
    test_add();
    test_subu();
    test_sub();
    test_backpressure();
    test_reset_mid_calc();
    test_back_to_back();
    test_single_chunk();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
